// File: rtl/bpfcap_pkg.sv
// Shared types and default widths for the bpfcap capture path
// (rd_ctrl, wr_ctrl, avmm_burst_arbiter).
package bpfcap_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_BURST_W  = 16;
    localparam int DEF_MAX_PEND = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_CMD   = 2'd1,
        WR_BURST = 2'd2
    } arb_state_t;

    typedef enum logic {
        LG_C0 = 1'b0,
        LG_C1 = 1'b1
    } client_t;

endpackage

// File: rtl/avmm_burst_arbiter.sv
// Burst-atomic round-robin arbiter sharing one Avalon-MM host between the
// read-only packet reader (C0) and the write-only capture writer (C1).
module avmm_burst_arbiter
    import bpfcap_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BURST_W  = DEF_BURST_W,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic [ADDR_W-1:0]                c0_address,
    input  logic                             c0_read,
    input  logic [BURST_W-1:0]               c0_burstcount,
    output logic                             c0_waitrequest,
    output logic [DATA_W-1:0]                c0_readdata,
    output logic                             c0_readdatavalid,

    input  logic [ADDR_W-1:0]                c1_address,
    input  logic                             c1_write,
    input  logic [DATA_W-1:0]                c1_writedata,
    input  logic [BURST_W-1:0]               c1_burstcount,
    output logic                             c1_waitrequest,

    output logic [ADDR_W-1:0]                h_address,
    output logic                             h_read,
    output logic                             h_write,
    output logic [DATA_W-1:0]                h_writedata,
    output logic [BURST_W-1:0]               h_burstcount,
    input  logic [DATA_W-1:0]                h_readdata,
    input  logic                             h_readdatavalid,
    input  logic                             h_waitrequest,

    output logic [1:0]                       grant,
    output logic [$clog2(MAX_PEND+1)-1:0]    pend_beats
);

    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam int CMP_W  = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;

    arb_state_t          state_q;
    client_t             last_grant_q;
    logic [1:0]          grant_q;
    logic [BURST_W-1:0]  beats_q;
    logic [PEND_W-1:0]   pend_q;
    logic [PEND_W-1:0]   pend_d;
    logic [CMP_W-1:0]    pend_sum;

    logic [BURST_W-1:0]  bc0_eff;
    logic [BURST_W-1:0]  bc1_eff;
    logic                rd_fits;
    logic                el0;
    logic                el1;
    logic                pick_c0;
    logic                rd_acc;
    logic                wr_acc;
    logic                rd_ret;

    // A zero burstcount is not legal on the host side, so it becomes one beat.
    assign bc0_eff = (c0_burstcount == '0) ? BURST_W'(1) : c0_burstcount;
    assign bc1_eff = (c1_burstcount == '0) ? BURST_W'(1) : c1_burstcount;

    assign rd_fits = (CMP_W'(pend_q) + CMP_W'(bc0_eff)) <= CMP_W'(MAX_PEND);
    assign el0     = c0_read & rd_fits;
    assign el1     = c1_write;
    assign pick_c0 = el0 & (~el1 | (last_grant_q == LG_C1));

    assign rd_acc  = (state_q == RD_CMD)   & c0_read  & ~h_waitrequest;
    assign wr_acc  = (state_q == WR_BURST) & c1_write & ~h_waitrequest;
    // Beats with nothing outstanding (e.g. in flight across a reset) are not counted.
    assign rd_ret  = h_readdatavalid & (pend_q != '0);

    always_comb begin
        pend_sum = CMP_W'(pend_q);
        if (rd_acc) pend_sum = pend_sum + CMP_W'(bc0_eff);
        if (rd_ret) pend_sum = pend_sum - CMP_W'(1);
        pend_d = PEND_W'(pend_sum);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= LG_C1;
            grant_q      <= 2'b00;
            beats_q      <= '0;
            pend_q       <= '0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                IDLE: begin
                    if (pick_c0) begin
                        state_q      <= RD_CMD;
                        grant_q      <= 2'b01;
                        last_grant_q <= LG_C0;
                    end else if (el1) begin
                        state_q      <= WR_BURST;
                        grant_q      <= 2'b10;
                        last_grant_q <= LG_C1;
                        beats_q      <= bc1_eff;
                    end
                end
                RD_CMD: begin
                    if (rd_acc) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
                WR_BURST: begin
                    // Grant is held through c1_write gaps until the last beat lands.
                    if (wr_acc) begin
                        beats_q <= beats_q - BURST_W'(1);
                        if (beats_q == BURST_W'(1)) begin
                            state_q <= IDLE;
                            grant_q <= 2'b00;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    // Host command is a mux of the granted client, selected by registered state only.
    always_comb begin
        h_address      = '0;
        h_read         = 1'b0;
        h_write        = 1'b0;
        h_writedata    = '0;
        h_burstcount   = '0;
        c0_waitrequest = 1'b1;
        c1_waitrequest = 1'b1;
        case (state_q)
            RD_CMD: begin
                h_address      = c0_address;
                h_read         = c0_read;
                h_burstcount   = bc0_eff;
                c0_waitrequest = h_waitrequest;
            end
            WR_BURST: begin
                h_address      = c1_address;
                h_write        = c1_write;
                h_writedata    = c1_writedata;
                h_burstcount   = bc1_eff;
                c1_waitrequest = h_waitrequest;
            end
            default: begin
                h_read  = 1'b0;
                h_write = 1'b0;
            end
        endcase
    end

    assign c0_readdata      = h_readdata;
    assign c0_readdatavalid = h_readdatavalid;
    assign grant            = grant_q;
    assign pend_beats       = pend_q;

endmodule

// File: tb/tb_avmm_burst_arbiter.sv
// Directed self-checking bench for avmm_burst_arbiter (MAX_PEND reduced to 8).
module tb_avmm_burst_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int BURST_W  = 16;
    localparam int MAX_PEND = 8;
    localparam int PEND_W   = $clog2(MAX_PEND + 1);

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [ADDR_W-1:0]   c0_address;
    logic                c0_read;
    logic [BURST_W-1:0]  c0_burstcount;
    logic                c0_waitrequest;
    logic [DATA_W-1:0]   c0_readdata;
    logic                c0_readdatavalid;
    logic [ADDR_W-1:0]   c1_address;
    logic                c1_write;
    logic [DATA_W-1:0]   c1_writedata;
    logic [BURST_W-1:0]  c1_burstcount;
    logic                c1_waitrequest;
    logic [ADDR_W-1:0]   h_address;
    logic                h_read;
    logic                h_write;
    logic [DATA_W-1:0]   h_writedata;
    logic [BURST_W-1:0]  h_burstcount;
    logic [DATA_W-1:0]   h_readdata;
    logic                h_readdatavalid;
    logic                h_waitrequest;
    logic [1:0]          grant;
    logic [PEND_W-1:0]   pend_beats;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    avmm_burst_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .MAX_PEND(MAX_PEND)
    ) dut (
        .clk(clk), .reset(reset),
        .c0_address(c0_address), .c0_read(c0_read), .c0_burstcount(c0_burstcount),
        .c0_waitrequest(c0_waitrequest), .c0_readdata(c0_readdata),
        .c0_readdatavalid(c0_readdatavalid),
        .c1_address(c1_address), .c1_write(c1_write), .c1_writedata(c1_writedata),
        .c1_burstcount(c1_burstcount), .c1_waitrequest(c1_waitrequest),
        .h_address(h_address), .h_read(h_read), .h_write(h_write),
        .h_writedata(h_writedata), .h_burstcount(h_burstcount),
        .h_readdata(h_readdata), .h_readdatavalid(h_readdatavalid),
        .h_waitrequest(h_waitrequest),
        .grant(grant), .pend_beats(pend_beats)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c0_address = '0; c0_read = 1'b0; c0_burstcount = '0;
        c1_address = '0; c1_write = 1'b0; c1_writedata = '0; c1_burstcount = '0;
        h_readdata = '0; h_readdatavalid = 1'b0; h_waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    bit wr_tab [13] = '{1,1,1,1,1,1,0,0,1,1,1,1,1};
    bit wt_tab [13] = '{0,0,1,0,1,0,0,0,1,0,0,0,0};

    initial begin
        int beat;
        int seen;

        // Reset state
        idle_inputs();
        #2;
        chk("rst_grant", grant, 2'b00);
        chk("rst_hread", h_read, 0);
        chk("rst_hwrite", h_write, 0);
        chk("rst_c0wait", c0_waitrequest, 1);
        chk("rst_c1wait", c1_waitrequest, 1);
        chk("rst_pend", pend_beats, 0);
        do_reset();

        // Single read burst, latency and pending-beat accounting
        c0_read = 1; c0_address = 32'h1000; c0_burstcount = 4; #1;
        chk("t1_idle_hread", h_read, 0);
        chk("t1_idle_c0wait", c0_waitrequest, 1);
        cyc();
        chk("t1_hread", h_read, 1);
        chk("t1_haddr", h_address, 32'h1000);
        chk("t1_hbc", h_burstcount, 4);
        chk("t1_grant", grant, 2'b01);
        chk("t1_c0wait", c0_waitrequest, 0);
        cyc();
        c0_read = 0; #1;
        chk("t1_hread_off", h_read, 0);
        chk("t1_pend4", pend_beats, 4);
        chk("t1_grant0", grant, 2'b00);
        for (int i = 0; i < 4; i++) begin
            h_readdatavalid = 1; h_readdata = 32'hD000 + i; #1;
            chk("t1_rdata", c0_readdata, 32'hD000 + i);
            chk("t1_rdv", c0_readdatavalid, 1);
            cyc();
        end
        h_readdatavalid = 0; #1;
        chk("t1_pend0", pend_beats, 0);
        h_readdatavalid = 1;
        cyc();
        h_readdatavalid = 0; #1;
        chk("t1_pend_sat", pend_beats, 0);

        // Contention: C0 first after reset, then C1, then C0 again
        do_reset();
        c0_read = 1; c0_address = 32'h2000; c0_burstcount = 2;
        c1_write = 1; c1_address = 32'h3000; c1_burstcount = 4; c1_writedata = 32'hA0;
        cyc();
        chk("t2_grant_c0", grant, 2'b01);
        chk("t2_hread", h_read, 1);
        chk("t2_hwrite0", h_write, 0);
        chk("t2_c1wait", c1_waitrequest, 1);
        chk("t2_haddr_c0", h_address, 32'h2000);
        cyc();
        c0_read = 0; #1;
        chk("t2_bubble", grant, 2'b00);
        chk("t2_pend2", pend_beats, 2);
        cyc();
        chk("t2_grant_c1", grant, 2'b10);
        chk("t2_haddr_c1", h_address, 32'h3000);
        chk("t2_hbc_c1", h_burstcount, 4);
        chk("t2_c0wait", c0_waitrequest, 1);
        for (int i = 0; i < 4; i++) begin
            c1_writedata = 32'hA0 + i; #1;
            chk("t2_wdata", h_writedata, 32'hA0 + i);
            chk("t2_c1wait_lo", c1_waitrequest, 0);
            cyc();
        end
        c0_read = 1; c0_address = 32'h2100; c0_burstcount = 1;
        c1_burstcount = 1; #1;
        chk("t2_bubble2", grant, 2'b00);
        cyc();
        chk("t2_rr_c0", grant, 2'b01);
        cyc();
        c0_read = 0;
        cyc();
        chk("t2_rr_c1", grant, 2'b10);
        cyc();
        c1_write = 0; #1;
        chk("t2_done", grant, 2'b00);
        chk("t2_pend3", pend_beats, 3);

        // Write burst 8 with host stalls and a mid-burst gap from C1
        do_reset();
        c1_write = 1; c1_address = 32'h4000; c1_burstcount = 8;
        cyc();
        c0_read = 1; c0_address = 32'h5000; c0_burstcount = 1;
        beat = 0;
        seen = 0;
        for (int t = 0; t < 13; t++) begin
            c1_write = wr_tab[t]; h_waitrequest = wt_tab[t]; c1_writedata = 32'hB0 + beat; #1;
            chk("t3_grant", grant, 2'b10);
            chk("t3_c0wait", c0_waitrequest, 1);
            chk("t3_hwrite", h_write, wr_tab[t]);
            if (wr_tab[t]) chk("t3_wdata", h_writedata, 32'hB0 + beat);
            if (h_write && !h_waitrequest) seen++;
            if (wr_tab[t] && !wt_tab[t]) beat++;
            cyc();
        end
        c1_write = 0; h_waitrequest = 0; #1;
        chk("t3_beats", seen, 8);
        chk("t3_idle", grant, 2'b00);
        chk("t3_hwrite_off", h_write, 0);
        cyc();
        chk("t3_c0_after", grant, 2'b01);
        chk("t3_c0_addr", h_address, 32'h5000);
        cyc();
        c0_read = 0;

        // Back-to-back C1 bursts with one bubble
        do_reset();
        c1_write = 1; c1_address = 32'h6000; c1_burstcount = 2;
        cyc();
        chk("t4_wr1", grant, 2'b10);
        cyc();
        cyc();
        chk("t4_bubble", grant, 2'b00);
        chk("t4_bubble_hw", h_write, 0);
        cyc();
        chk("t4_wr2", grant, 2'b10);
        cyc();
        cyc();
        c1_write = 0; #1;
        chk("t4_done", grant, 2'b00);

        // Outstanding read limit, plus accept with simultaneous return
        do_reset();
        c0_read = 1; c0_address = 32'h7000; c0_burstcount = 4;
        cyc();
        chk("t5_rd1", grant, 2'b01);
        cyc();
        chk("t5_pend4", pend_beats, 4);
        cyc();
        chk("t5_rd2", grant, 2'b01);
        cyc();
        chk("t5_pend8", pend_beats, 8);
        cyc();
        chk("t5_full_grant", grant, 2'b00);
        chk("t5_full_wait", c0_waitrequest, 1);
        cyc();
        chk("t5_full_grant2", grant, 2'b00);
        h_readdatavalid = 1;
        cyc();
        cyc();
        cyc();
        chk("t5_pend5", pend_beats, 5);
        chk("t5_still_blocked", grant, 2'b00);
        cyc();
        h_readdatavalid = 0; #1;
        chk("t5_pend4b", pend_beats, 4);
        chk("t5_wait4", c0_waitrequest, 1);
        cyc();
        chk("t5_rd3", grant, 2'b01);
        chk("t5_rd3_wait", c0_waitrequest, 0);
        h_readdatavalid = 1;
        cyc();
        h_readdatavalid = 0; c0_read = 0; #1;
        chk("t5_pend7", pend_beats, 7);

        // Async reset in the middle of a write burst
        do_reset();
        c1_write = 1; c1_address = 32'h8000; c1_burstcount = 8;
        cyc();
        cyc();
        cyc();
        chk("t6_beat3", h_write, 1);
        reset = 0; h_readdatavalid = 1; h_readdata = 32'hEE; #1;
        chk("t6_hwrite", h_write, 0);
        chk("t6_c0wait", c0_waitrequest, 1);
        chk("t6_c1wait", c1_waitrequest, 1);
        chk("t6_grant", grant, 2'b00);
        chk("t6_rdv_pass", c0_readdatavalid, 1);
        chk("t6_rdata_pass", c0_readdata, 32'hEE);
        c1_write = 0;
        cyc();
        reset = 1;
        cyc();
        h_readdatavalid = 0; #1;
        chk("t6_pend0", pend_beats, 0);
        c1_write = 1; c1_address = 32'h9000; c1_burstcount = 2;
        cyc();
        chk("t6_fresh_grant", grant, 2'b10);
        chk("t6_fresh_addr", h_address, 32'h9000);
        chk("t6_fresh_bc", h_burstcount, 2);
        cyc();
        cyc();
        c1_write = 0; #1;
        chk("t6_fresh_done", grant, 2'b00);

        // Zero burstcount is one beat
        do_reset();
        c0_read = 1; c0_address = 32'hA000; c0_burstcount = 0;
        cyc();
        chk("t7_hbc1", h_burstcount, 1);
        cyc();
        c0_read = 0; #1;
        chk("t7_pend1", pend_beats, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/avmm_burst_arbiter.md
# avmm_burst_arbiter

Shares one Avalon-MM host port between the packet reader (read-only client C0, fed by rd_ctrl) and the capture writer (write-only client C1, fed by wr_ctrl), so the capture path can run over a single SDRAM/HPS bridge instead of two. Grants are burst-atomic and round-robin. The number of outstanding read beats is bounded so the reader FIFO cannot be overrun. Sits in bpfcap_top between rd_ctrl/wr_ctrl and the memory interconnect.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- BURST_W, 16, burstcount width
- MAX_PEND, 64, max read beats in flight (≥ max burst)
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- c0_address  in  ADDR_W  reader address
- c0_read  in  1  reader command
- c0_burstcount  in  BURST_W  reader burst length
- c0_waitrequest  out  1  reader stall
- c0_readdata  out  DATA_W  read data to reader
- c0_readdatavalid  out  1  read beat valid
- c1_address  in  ADDR_W  writer address
- c1_write  in  1  writer beat
- c1_writedata  in  DATA_W  write data
- c1_burstcount  in  BURST_W  writer burst length
- c1_waitrequest  out  1  writer stall
- h_address, h_read, h_write, h_writedata, h_burstcount  out  per client  host command
- h_readdata  in  DATA_W; h_readdatavalid  in  1; h_waitrequest  in  1
- grant  out  2  one-hot current grant (status register)
- pend_beats  out  $clog2(MAX_PEND+1)  read beats in flight

## Operation
- States: IDLE, RD_CMD, WR_BURST (registered).
- IDLE: h_read=h_write=0, h_address/h_writedata/h_burstcount=0, c0/c1_waitrequest=1, grant=00.
- Arbitration in IDLE, resolved at the clock edge:
  - C0 is eligible if c0_read and pend_beats+c0_burstcount ≤ MAX_PEND.
  - C1 is eligible if c1_write.
  - Both eligible: grant the client not granted last (last_grant register, reset value C1, so C0 wins first).
  - Enter RD_CMD or WR_BURST accordingly.
- RD_CMD: host command mirrors C0 combinationally; c0_waitrequest=h_waitrequest; c1_waitrequest=1. On h_read & !h_waitrequest: pend_beats += burstcount, go to IDLE.
- WR_BURST:
  - Entry loads beat counter with c1_burstcount.
  - Host command mirrors C1; c1_waitrequest=h_waitrequest; c0_waitrequest=1.
  - Each h_write & !h_waitrequest decrements the counter; go to IDLE on the last beat.
  - The grant holds while c1_write is deasserted mid-burst; a write burst is never interrupted.
- Read data path: c0_readdata=h_readdata and c0_readdatavalid=h_readdatavalid, combinational pass-through in every state. Each valid beat decrements pend_beats.
- Width rules:
  - burstcount 0 is treated as 1.
  - pend_beats saturates at 0; a readdatavalid with pend_beats=0 is passed through but not counted.
- Simultaneous read accept and readdatavalid: pend_beats += burstcount−1 in the same cycle.

## Timing
- Arbitration latency: a request first seen in IDLE at cycle N drives the host at N+1.
- One IDLE bubble cycle follows every granted command or burst.
- Back-to-back C1 bursts with C0 idle: C1 is regranted after one bubble.
- Async reset at any time: state=IDLE, counters=0, last_grant=C1, all host strobes=0, both waitrequests=1.
- In-flight read data arriving after reset is still forwarded to C0 and not counted.
- No combinational path from h_waitrequest to h_read/h_write.

## Structure
- bpfcap_pkg holds arb_state_t (IDLE/RD_CMD/WR_BURST) and the ADDR_W/DATA_W/BURST_W defaults, shared with rd_ctrl/wr_ctrl.
- Single module; no sub-module warranted.

## Test plan
- Reset, then C0 read burst 4 @0x1000 with no waitrequest → h_read high for 1 cycle at N+1, pend_beats=4, 4 readdatavalid beats bring it back to 0.
- C0 and C1 request in the same cycle → C0 granted first, C1 (burst 4) second, then C0 again on the next contention.
- C1 burst 8 with h_waitrequest high on beats 3–5 and c1_write dropped 2 cycles mid-burst → exactly 8 host beats, C0 stays stalled until the last beat.
- MAX_PEND=8, C0 issues burst 4 twice with no returned data → third burst 4 waits (c0_waitrequest=1) until 4 beats have returned.
- Reset asserted mid WR_BURST (beat 3 of 8) → same cycle h_write=0, both waitrequests=1, grant=00; a fresh burst works after release.
- c0_burstcount=0 → treated as 1, pend_beats increments by 1.
